// File: rtl/dip_switch_debouncer_pkg.sv
// Shared constants and types for the DIP-switch debouncer.
package dip_switch_debouncer_pkg;

  localparam int unsigned SWITCH_BYTES            = 8;
  localparam logic [7:0]  SWITCH_RESET_BYTE       = 8'hFF;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;

  typedef logic [7:0] switch_byte_t;

endpackage

// File: rtl/dip_switch_debouncer_if.sv
// Pin-side and bank-side signal bundle of the DIP-switch debouncer.
interface dip_switch_debouncer_if;
  import dip_switch_debouncer_pkg::*;

  switch_byte_t raw_switch0, raw_switch1, raw_switch2, raw_switch3;
  switch_byte_t raw_switch4, raw_switch5, raw_switch6, raw_switch7;
  logic         irq_ack;
  switch_byte_t dip_switch0, dip_switch1, dip_switch2, dip_switch3;
  switch_byte_t dip_switch4, dip_switch5, dip_switch6, dip_switch7;
  logic [7:0]   changed;
  logic         irq;

  modport master (
    output raw_switch0, raw_switch1, raw_switch2, raw_switch3,
    output raw_switch4, raw_switch5, raw_switch6, raw_switch7,
    output irq_ack,
    input  dip_switch0, dip_switch1, dip_switch2, dip_switch3,
    input  dip_switch4, dip_switch5, dip_switch6, dip_switch7,
    input  changed, irq
  );

  modport slave (
    input  raw_switch0, raw_switch1, raw_switch2, raw_switch3,
    input  raw_switch4, raw_switch5, raw_switch6, raw_switch7,
    input  irq_ack,
    output dip_switch0, dip_switch1, dip_switch2, dip_switch3,
    output dip_switch4, dip_switch5, dip_switch6, dip_switch7,
    output changed, irq
  );

endinterface

// File: rtl/dip_switch_debouncer_byte.sv
// One byte: two-flop synchronizer, change detector, debounce counter and committed value.
module switch_byte_debouncer
  import dip_switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  switch_byte_t i_raw,
  output switch_byte_t o_stable,
  output logic         o_commit
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  switch_byte_t     r_sync1, r_sync2, r_sync_d, r_stable;
  switch_byte_t     w_stable_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             w_commit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= SWITCH_RESET_BYTE;
      r_sync2  <= SWITCH_RESET_BYTE;
      r_sync_d <= SWITCH_RESET_BYTE;
      r_stable <= SWITCH_RESET_BYTE;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= i_raw;
      r_sync2  <= r_sync1;
      r_sync_d <= r_sync2;
      r_stable <= w_stable_d;
      r_cnt    <= w_cnt_d;
    end
  end

  // First match wins; the counter only returns to zero, it never wraps.
  always_comb begin
    w_cnt_d    = '0;
    w_stable_d = r_stable;
    w_commit   = 1'b0;
    if (r_sync2 == r_stable) begin
      w_cnt_d = '0;
    end else if (r_sync2 != r_sync_d) begin
      w_cnt_d = '0;
    end else if (r_cnt == CntMax) begin
      w_stable_d = r_sync2;
      w_commit   = 1'b1;
    end else begin
      w_cnt_d = r_cnt + 1'b1;
    end
  end

  assign o_stable = r_stable;
  assign o_commit = w_commit;

endmodule

// File: rtl/dip_switch_debouncer.sv
// Debounces eight DIP-switch bytes; sticky changed flags and irq exist only when
// SWITCH_IRQ_EN is defined, otherwise they are tied low and irq_ack is ignored.
module dip_switch_debouncer
  import dip_switch_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  dip_switch_debouncer_if.slave  bus
);

  switch_byte_t            w_raw    [SWITCH_BYTES];
  switch_byte_t            w_stable [SWITCH_BYTES];
  logic [SWITCH_BYTES-1:0] w_commit;

  assign w_raw[0] = bus.raw_switch0;
  assign w_raw[1] = bus.raw_switch1;
  assign w_raw[2] = bus.raw_switch2;
  assign w_raw[3] = bus.raw_switch3;
  assign w_raw[4] = bus.raw_switch4;
  assign w_raw[5] = bus.raw_switch5;
  assign w_raw[6] = bus.raw_switch6;
  assign w_raw[7] = bus.raw_switch7;

  for (genvar i = 0; i < SWITCH_BYTES; i++) begin : g_byte
    switch_byte_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_byte (
      .clk      (clk),
      .reset    (reset),
      .i_raw    (w_raw[i]),
      .o_stable (w_stable[i]),
      .o_commit (w_commit[i])
    );
  end

  assign bus.dip_switch0 = w_stable[0];
  assign bus.dip_switch1 = w_stable[1];
  assign bus.dip_switch2 = w_stable[2];
  assign bus.dip_switch3 = w_stable[3];
  assign bus.dip_switch4 = w_stable[4];
  assign bus.dip_switch5 = w_stable[5];
  assign bus.dip_switch6 = w_stable[6];
  assign bus.dip_switch7 = w_stable[7];

`ifdef SWITCH_IRQ_EN
  logic [SWITCH_BYTES-1:0] r_changed, w_changed_d;

  // Ack clears first, then this edge's commits are OR'd back in: set wins.
  always_comb begin
    w_changed_d = r_changed;
    if (bus.irq_ack) begin
      w_changed_d = '0;
    end
    w_changed_d = w_changed_d | w_commit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_changed <= '0;
    end else begin
      r_changed <= w_changed_d;
    end
  end

  assign bus.changed = r_changed;
  assign bus.irq     = |r_changed;
`else
  logic [SWITCH_BYTES:0] w_unused_irq;
  assign w_unused_irq = {bus.irq_ack, w_commit};

  assign bus.changed = '0;
  assign bus.irq     = 1'b0;
`endif

endmodule

// File: doc/dip_switch_debouncer.md
# dip_switch_debouncer

Conditions the 64 raw DIP-switch pins on the board before they reach the switch bank peripheral, which reads them through its `dip_switch0`..`dip_switch7` byte inputs. Each byte passes through a two-flop synchronizer and a per-byte debounce counter, so a byte changes only after it has been stable for a fixed number of cycles. Each byte also carries a sticky changed flag and a level interrupt request for the CPU's interrupt controller. Pin polarity is preserved: the pins are active-low and the downstream bank inverts them.

## Interface
- `DEBOUNCE_CYCLES`, default 250000 (10 ms at 25 MHz): consecutive stable cycles required to commit a byte; legal range ≥ 1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)+1`: debounce counter width.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low (asserted at 0).
- `raw_switch0`..`raw_switch7` input 8 each: unsynchronized pin bytes.
- `irq_ack` input 1: clears all changed flags.
- `dip_switch0`..`dip_switch7` output 8 each: debounced bytes, feeding the switch bank.
- `changed` output 8: sticky per-byte changed flags.
- `irq` output 1: OR of `changed`.

## Operation
- Per byte i: `sync1` ← raw; `sync2` ← `sync1`; `sync_d` ← `sync2`; `stable` drives `dip_switch<i>`.
- Counter rule, evaluated every edge, first match wins:
  - If `sync2 == stable`, then cnt ← 0.
  - Else if `sync2 != sync_d` (the value moved), then cnt ← 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, then `stable` ← `sync2`, cnt ← 0, and `changed[i]` is set.
  - Otherwise cnt ← cnt+1.
- A glitch shorter than the window is discarded.
- A value that moves to a third value mid-count restarts the window.
- The counter saturates only through the commit rule; it never wraps.
- The eight bytes are fully independent. Several bytes may commit on the same edge.
- `changed[i]` is set on its byte's commit and cleared when `irq_ack` is 1. A commit and `irq_ack` on the same edge leave that byte's flag set: set wins.
- `irq` = |`changed`, combinational from the flags.

## Timing
- Reset values while `reset` is 0:
  - `sync1`, `sync2`, `sync_d`, `stable`: 8'hFF. All switches read "off", so the downstream bank reads 0.
  - cnt: 0.
  - `changed`: 8'h00.
  - `irq`: 0.
- Latency: a raw change is sampled at edge k and held. `stable` updates at edge k+2+DEBOUNCE_CYCLES and is visible after that edge.
- A raw pulse of at most DEBOUNCE_CYCLES edges produces no commit.
- Asserting reset mid-count discards the count and restores the reset values immediately, asynchronously.
- Release of reset is synchronous to `clk` through the team's standard reset synchronizer, which is outside this block.
- `irq_ack` takes effect on the next edge. `irq` falls in the cycle after that edge unless a commit coincides.

## Configuration
- `SWITCH_IRQ_EN` defined:
  - The changed-flag registers, `irq_ack` handling and `irq` are built as described above.
- `SWITCH_IRQ_EN` undefined:
  - No flag registers are built; `changed` is tied to 8'h00 and `irq` to 0.
  - `irq_ack` is ignored.
  - Debounce behaviour and latency are identical.
  - The port list is unchanged in both builds.

## Structure
- Shared package holds:
  - `SWITCH_BYTES` = 8.
  - `SWITCH_RESET_BYTE` = 8'hFF.
  - `DEBOUNCE_CYCLES_DEFAULT` = 250000.
  - A `switch_byte_t` 8-bit typedef.
- Sub-module `switch_byte_debouncer` contains one byte's synchronizer, `sync_d`, counter, `stable` register and commit pulse. It is instantiated 8 times.
- The top level holds the flags, the ack logic and the `irq` OR.

## Test plan
All cases use DEBOUNCE_CYCLES=4 and `SWITCH_IRQ_EN` defined, except the last.
- Reset check: hold `reset`=0 with raw=8'h00 → all `dip_switch` = 8'hFF, `changed`=0, `irq`=0.
- Single-byte commit: release reset; set `raw_switch3`=8'hA5 before edge k and hold → `dip_switch3`=8'hA5 after edge k+6, not before; `changed`=8'h08, `irq`=1; the other bytes stay at 8'hFF.
- Glitch rejection: `raw_switch0`=8'h00 held for exactly 4 edges, then back to 8'hFF → `dip_switch0` stays 8'hFF and `changed[0]` stays 0.
- Mid-count value move: `raw_switch1`=8'h0F for 3 edges, then 8'hF0 held → commits to 8'hF0 exactly 6 edges after the move; 8'h0F never appears.
- Set-wins on ack: `irq_ack` pulsed on byte 5's commit edge → `changed[5]`=1 afterwards; a second `irq_ack` → `changed`=0, `irq`=0. Reset asserted mid-count on byte 2 → `dip_switch2` stays 8'hFF.
- Macro off: rebuild without `SWITCH_IRQ_EN` and rerun the single-byte commit → identical `dip_switch3` timing; `changed`=0 and `irq`=0 throughout.
